// File: rtl/mdu_iterative.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// UNROLL bits resolved per cycle, with busy/done handshake for the hazard unit.
module mdu_iterative #(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int N  = XLEN / UNROLL;
    localparam int CW = $clog2(N + 1);

    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t              r_state;
    logic [2:0]          r_op;
    logic                r_neg;
    logic                r_fast;
    logic [CW-1:0]       r_cnt;
    logic [XLEN-1:0]     r_hi;
    logic [XLEN-1:0]     r_lo;
    logic [XLEN-1:0]     r_m;
    logic [XLEN-1:0]     r_result;
    logic                r_busy;
    logic                r_done;

    logic                w_a_sgn;
    logic                w_b_sgn;
    logic [XLEN-1:0]     w_a_abs;
    logic [XLEN-1:0]     w_b_abs;
    logic                w_neg;
    logic                w_div0;
    logic                w_ovf;
    logic [XLEN-1:0]     w_fast_val;
    logic [2*XLEN-1:0]   w_step;
    logic [2*XLEN-1:0]   w_prod;
    logic [XLEN-1:0]     w_div_sel;
    logic [XLEN-1:0]     w_fix_res;

    // {hi,lo} holds running partial product in hi and the unconsumed multiplier in lo.
    function automatic logic [2*XLEN-1:0] mul_step(input logic [XLEN-1:0] hi,
                                                   input logic [XLEN-1:0] lo,
                                                   input logic [XLEN-1:0] m);
        logic [XLEN:0]   s;
        logic [XLEN-1:0] h;
        logic [XLEN-1:0] l;
        h = hi;
        l = lo;
        for (int i = 0; i < UNROLL; i++) begin
            s = {1'b0, h} + (l[0] ? {1'b0, m} : '0);
            l = {s[0], l[XLEN-1:1]};
            h = s[XLEN:1];
        end
        return {h, l};
    endfunction

    // hi is the partial remainder; lo shifts the dividend out and the quotient in.
    function automatic logic [2*XLEN-1:0] div_step(input logic [XLEN-1:0] hi,
                                                   input logic [XLEN-1:0] lo,
                                                   input logic [XLEN-1:0] m);
        logic [XLEN:0]   r;
        logic [XLEN-1:0] h;
        logic [XLEN-1:0] l;
        h = hi;
        l = lo;
        for (int i = 0; i < UNROLL; i++) begin
            r = {h, l[XLEN-1]};
            l = {l[XLEN-2:0], 1'b0};
            if (r >= {1'b0, m}) begin
                r    = r - {1'b0, m};
                l[0] = 1'b1;
            end
            h = r[XLEN-1:0];
        end
        return {h, l};
    endfunction

    always_comb begin
        w_a_sgn    = a[XLEN-1] & (op == OP_MULH || op == OP_MULHSU || op == OP_DIV || op == OP_REM);
        w_b_sgn    = b[XLEN-1] & (op == OP_MULH || op == OP_DIV || op == OP_REM);
        w_a_abs    = w_a_sgn ? -a : a;
        w_b_abs    = w_b_sgn ? -b : b;
        w_neg      = (op[2] & op[1]) ? w_a_sgn : (w_a_sgn ^ w_b_sgn);
        w_div0     = op[2] & (b == '0);
        w_ovf      = (op == OP_DIV || op == OP_REM) && (a == MIN_NEG) && (b == '1);
        w_fast_val = '0;
        if (w_div0)
            w_fast_val = op[1] ? a : '1;
        else if (w_ovf)
            w_fast_val = op[1] ? '0 : a;
    end

    always_comb begin
        w_step = r_op[2] ? div_step(r_hi, r_lo, r_m) : mul_step(r_hi, r_lo, r_m);
    end

    always_comb begin
        w_prod    = r_neg ? -{r_hi, r_lo} : {r_hi, r_lo};
        w_div_sel = r_op[1] ? r_hi : r_lo;
        if (r_neg)
            w_div_sel = -w_div_sel;
        if (r_fast)
            w_fix_res = r_lo;
        else if (r_op[2])
            w_fix_res = w_div_sel;
        else if (r_op[1:0] == 2'b00)
            w_fix_res = w_prod[XLEN-1:0];
        else
            w_fix_res = w_prod[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_op     <= '0;
            r_neg    <= 1'b0;
            r_fast   <= 1'b0;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_m      <= '0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && !flush) begin
                        r_op   <= op;
                        r_neg  <= w_neg;
                        r_hi   <= '0;
                        r_busy <= 1'b1;
                        if (w_div0 || w_ovf) begin
                            r_fast  <= 1'b1;
                            r_lo    <= w_fast_val;
                            r_m     <= '0;
                            r_cnt   <= '0;
                            r_state <= S_FIX;
                        end else begin
                            r_fast  <= 1'b0;
                            r_lo    <= op[2] ? w_a_abs : w_b_abs;
                            r_m     <= op[2] ? w_b_abs : w_a_abs;
                            r_cnt   <= CW'(N);
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (flush) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        {r_hi, r_lo} <= w_step;
                        r_cnt        <= r_cnt - CW'(1);
                        if (r_cnt == CW'(1))
                            r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_busy <= 1'b0;
                    if (flush) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_result <= w_fix_res;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

endmodule

// File: tb/tb_mdu_iterative.sv
// Bench for mdu_iterative: directed RV32M cases, flush/reset behaviour and
// randomized operations checked against a plain-arithmetic reference model.
module tb_mdu_iterative;

    logic        clk;
    logic        reset;
    logic        start;
    logic        start4;
    logic        flush;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        busy4;
    logic        done4;
    logic [31:0] result4;

    int checks   = 0;
    int failures = 0;
    logic [31:0] last32;

    mdu_iterative #(.XLEN(32), .UNROLL(1)) u_dut (
        .clk(clk), .reset(reset), .start(start), .flush(flush), .op(op),
        .a(a), .b(b), .busy(busy), .done(done), .result(result)
    );

    mdu_iterative #(.XLEN(32), .UNROLL(4)) u_dut4 (
        .clk(clk), .reset(reset), .start(start4), .flush(flush), .op(op),
        .a(a), .b(b), .busy(busy4), .done(done4), .result(result4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_mdu(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint          sx;
        longint          sy;
        longint          p;
        longint unsigned ux;
        longint unsigned uy;
        longint unsigned pu;
        logic [31:0]     r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'b0, x};
        uy = {32'b0, y};
        r  = '0;
        case (o)
            3'd0: begin pu = ux * uy; r = pu[31:0]; end
            3'd1: begin p = sx * sy; r = p[63:32]; end
            3'd2: begin p = sx * longint'(uy); r = p[63:32]; end
            3'd3: begin pu = ux * uy; r = pu[63:32]; end
            3'd4: begin if (y == 0) r = '1; else begin p = sx / sy; r = p[31:0]; end end
            3'd5: begin if (y == 0) r = '1; else begin pu = ux / uy; r = pu[31:0]; end end
            3'd6: begin if (y == 0) r = x; else begin p = sx % sy; r = p[31:0]; end end
            default: begin if (y == 0) r = x; else begin pu = ux % uy; r = pu[31:0]; end end
        endcase
        return r;
    endfunction

    function automatic int lat_of(input bit u4, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        bit fast;
        fast = o[2] && ((y == 0) || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF));
        return fast ? 2 : (u4 ? 10 : 34);
    endfunction

    // Accept in cycle 0; returns at the sample point of cycle 1.
    task automatic launch(input bit u4, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        op = o; a = x; b = y;
        if (u4) start4 = 1'b1; else start = 1'b1;
        @(negedge clk);
        start = 1'b0; start4 = 1'b0;
        op = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom;
    endtask

    task automatic wait_done(input bit u4, input int c0, input int lat, input logic [31:0] exp, input string tag);
        int cyc;
        bit busy_ok;
        cyc = c0;
        busy_ok = 1'b1;
        while (cyc < 200) begin
            if (u4 ? done4 : done) break;
            if (!(u4 ? busy4 : busy)) busy_ok = 1'b0;
            @(negedge clk);
            cyc++;
        end
        check({tag, "_latency"}, cyc, lat);
        check({tag, "_busy_during"}, busy_ok, 1'b1);
        check({tag, "_busy_at_done"}, u4 ? busy4 : busy, 1'b0);
        check({tag, "_result"}, u4 ? result4 : result, exp);
        if (!u4) last32 = exp;
    endtask

    task automatic run(input bit u4, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] exp, input int lat, input string tag);
        launch(u4, o, x, y);
        wait_done(u4, 1, lat, exp, tag);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; start4 = 1'b0; flush = 1'b0;
        op = '0; a = '0; b = '0; last32 = '0;
        #1 reset = 1'b0;
        #2;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_result", result, 32'h0);
        check("rst_result4", result4, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        run(0, 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, "mul");
        run(0, 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, "mulh");
        run(0, 3'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, "mulhu");
        run(0, 3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 34, "mulhsu");
        run(0, 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, "div");
        run(0, 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, "rem");
        run(0, 3'd5, 32'd100, 32'd7, 32'd14, 34, "divu");
        run(0, 3'd7, 32'd100, 32'd7, 32'd2, 34, "remu");
        run(0, 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 2, "divu_by0");
        run(0, 3'd6, 32'h8000_0001, 32'd0, 32'h8000_0001, 2, "rem_by0");
        run(0, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2, "div_ovf");
        run(0, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 2, "rem_ovf");

        // start in the DONE cycle is held into the following IDLE cycle
        launch(0, 3'd0, 32'd9, 32'd9);
        wait_done(0, 1, 34, 32'd81, "b2b_first");
        op = 3'd0; a = 32'd6; b = 32'd7; start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_done(0, 1, 34, 32'd42, "b2b_second");

        // start while busy is ignored
        launch(0, 3'd0, 32'd3, 32'd5);
        repeat (4) @(negedge clk);
        op = 3'd4; a = 32'd100; b = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(0, 6, 34, 32'd15, "busy_ignore");

        // flush together with start in IDLE
        @(negedge clk);
        op = 3'd0; a = 32'd2; b = 32'd2; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("flush_start_idle_busy", busy, 1'b0);

        // flush during FIX of a fast-path op
        launch(0, 3'd5, 32'd5, 32'd0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_fix_done", done, 1'b0);
        check("flush_fix_result", result, last32);

        // flush at cycle 10 of a DIV, then MUL started at cycle 12
        launch(0, 3'd4, 32'd1000, 32'd3);
        check("flush_calc_busy_before", busy, 1'b1);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_calc_busy", busy, 1'b0);
        check("flush_calc_done", done, 1'b0);
        check("flush_calc_result", result, last32);
        run(0, 3'd0, 32'd3, 32'd4, 32'd12, 34, "after_flush");

        // async reset mid-CALC
        launch(0, 3'd0, 32'h1234, 32'h10);
        repeat (5) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("arst_busy", busy, 1'b0);
        check("arst_done", done, 1'b0);
        check("arst_result", result, 32'h0);
        last32 = '0;
        op = 3'd0; a = 32'd2; b = 32'd3; start = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_start_busy", busy, 1'b0);
        check("rst_start_result", result, 32'h0);
        start = 1'b0;
        reset = 1'b1;

        run(1, 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 10, "mul_u4");
        run(1, 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 10, "div_u4");

        for (int i = 0; i < 50; i++) begin
            bit          u4;
            logic [2:0]  o;
            logic [31:0] x;
            logic [31:0] y;
            int          sel;
            u4  = (i >= 38);
            o   = 3'($urandom_range(0, 7));
            x   = $urandom;
            y   = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) y = '0;
            else if (sel == 1) begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
            else if (sel == 2) y = $urandom_range(1, 15);
            else if (sel == 3) x = $urandom_range(0, 100);
            run(u4, o, x, y, ref_mdu(o, x, y), lat_of(u4, o, x, y), $sformatf("rnd%0d_op%0d", i, o));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
